// File: rtl/rtype_control_seq_pkg.sv
// Shared definitions for the R-type control sequencer: opcodes, ALU op codes,
// instruction classes and sequencer states.
package rtype_control_seq_pkg;

    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_SHR = 5'd5;
    localparam logic [4:0] OP_SHL = 5'd6;
    localparam logic [4:0] OP_ROR = 5'd7;
    localparam logic [4:0] OP_ROL = 5'd8;
    localparam logic [4:0] OP_AND = 5'd9;
    localparam logic [4:0] OP_OR  = 5'd10;
    localparam logic [4:0] OP_MUL = 5'd14;
    localparam logic [4:0] OP_DIV = 5'd15;
    localparam logic [4:0] OP_NEG = 5'd16;
    localparam logic [4:0] OP_NOT = 5'd17;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_SHR = 4'b0100,
        ALU_SHL = 4'b0101,
        ALU_ROR = 4'b0110,
        ALU_ROL = 4'b0111,
        ALU_MUL = 4'b1000,
        ALU_DIV = 4'b1001,
        ALU_NEG = 4'b1010,
        ALU_NOT = 4'b1011
    } alu_op_t;

    typedef enum logic [1:0] {
        CLS_BINARY,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_NONE
    } instr_class_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_t;

endpackage

// File: rtl/rtype_control_seq_decode.sv
// Combinational IR decode: instruction class, ALU op, one-hot register
// selects and the illegal flag (bad opcode or out-of-range used index).
module rtype_decode
    import rtype_control_seq_pkg::*;
#(
    parameter int unsigned NREG = 16
) (
    input  logic [31:0]     ir,
    output instr_class_t    cls,
    output alu_op_t         alu_op,
    output logic [NREG-1:0] ra_oh,
    output logic [NREG-1:0] rb_oh,
    output logic [NREG-1:0] rc_oh,
    output logic            illegal
);

    logic [4:0]   op;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [3:0]   rc;
    instr_class_t raw_cls;
    logic         idx_bad;
    logic         unused_ir_bits;

    assign op = ir[31:27];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    function automatic logic idx_ok(input logic [3:0] idx);
        return 32'(idx) < NREG;
    endfunction

    function automatic logic [NREG-1:0] to_onehot(input logic [3:0] idx);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            oh[k] = (32'(idx) == k);
        end
        return oh;
    endfunction

    always_comb begin
        raw_cls = CLS_NONE;
        alu_op  = ALU_AND;
        case (op)
            OP_ADD: begin raw_cls = CLS_BINARY; alu_op = ALU_ADD; end
            OP_SUB: begin raw_cls = CLS_BINARY; alu_op = ALU_SUB; end
            OP_SHR: begin raw_cls = CLS_BINARY; alu_op = ALU_SHR; end
            OP_SHL: begin raw_cls = CLS_BINARY; alu_op = ALU_SHL; end
            OP_ROR: begin raw_cls = CLS_BINARY; alu_op = ALU_ROR; end
            OP_ROL: begin raw_cls = CLS_BINARY; alu_op = ALU_ROL; end
            OP_AND: begin raw_cls = CLS_BINARY; alu_op = ALU_AND; end
            OP_OR:  begin raw_cls = CLS_BINARY; alu_op = ALU_OR;  end
            OP_MUL: begin raw_cls = CLS_MULDIV; alu_op = ALU_MUL; end
            OP_DIV: begin raw_cls = CLS_MULDIV; alu_op = ALU_DIV; end
            OP_NEG: begin raw_cls = CLS_UNARY;  alu_op = ALU_NEG; end
            OP_NOT: begin raw_cls = CLS_UNARY;  alu_op = ALU_NOT; end
            default: begin raw_cls = CLS_NONE;  alu_op = ALU_AND; end
        endcase
    end

    // Only the register fields an instruction class actually uses are range-checked.
    always_comb begin
        idx_bad = 1'b0;
        case (raw_cls)
            CLS_BINARY: idx_bad = !idx_ok(ra) || !idx_ok(rb) || !idx_ok(rc);
            CLS_UNARY,
            CLS_MULDIV: idx_bad = !idx_ok(ra) || !idx_ok(rb);
            default:    idx_bad = 1'b0;
        endcase
    end

    assign illegal = (raw_cls == CLS_NONE) || idx_bad;
    assign cls     = illegal ? CLS_NONE : raw_cls;
    assign ra_oh   = to_onehot(ra);
    assign rb_oh   = to_onehot(rb);
    assign rc_oh   = to_onehot(rc);

endmodule

// File: rtl/rtype_control_seq.sv
// Hard-wired control sequencer: instruction fetch then execute/writeback for
// register-register ALU, unary and MUL/DIV instructions, one step per clock.
module rtype_control_seq
    import rtype_control_seq_pkg::*;
#(
    parameter int unsigned NREG       = 16,
    parameter int unsigned MULDIV_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mem_ready,
    input  logic [31:0]     ir,
    output logic            pc_out,
    output logic            mar_in,
    output logic            inc_pc,
    output logic            pc_in,
    output logic            read,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            z_low_out,
    output logic            z_high_out,
    output logic            hi_in,
    output logic            lo_in,
    output logic [NREG-1:0] gpr_in,
    output logic [NREG-1:0] gpr_out,
    output logic [3:0]      alu_op,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    localparam logic [3:0] LAT_LAST = 4'(MULDIV_LAT - 1);

    state_t          state;
    state_t          state_n;
    logic [3:0]      lat_cnt;
    instr_class_t    cls;
    alu_op_t         dec_alu;
    alu_op_t         alu_sel;
    logic [NREG-1:0] ra_oh;
    logic [NREG-1:0] rb_oh;
    logic [NREG-1:0] rc_oh;
    logic            dec_illegal;

    rtype_decode #(.NREG(NREG)) u_decode (
        .ir      (ir),
        .cls     (cls),
        .alu_op  (dec_alu),
        .ra_oh   (ra_oh),
        .rb_oh   (rb_oh),
        .rc_oh   (rc_oh),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counts cycles spent in T4; cleared in every other state so each MUL/DIV starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (state == S_T4) begin
            lat_cnt <= lat_cnt + 4'd1;
        end else begin
            lat_cnt <= '0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start ? S_T0 : S_IDLE;
            S_T0:    state_n = S_T1;
            S_T1:    state_n = mem_ready ? S_T2 : S_T1W;
            S_T1W:   state_n = mem_ready ? S_T2 : S_T1W;
            S_T2:    state_n = S_T3;
            S_T3: begin
                case (cls)
                    CLS_NONE:  state_n = S_IDLE;
                    CLS_UNARY: state_n = S_T5;
                    default:   state_n = S_T4;
                endcase
            end
            S_T4: begin
                if (cls == CLS_MULDIV && lat_cnt != LAT_LAST) begin
                    state_n = S_T4;
                end else begin
                    state_n = S_T5;
                end
            end
            S_T5:    state_n = (cls == CLS_MULDIV) ? S_T6 : S_IDLE;
            S_T6:    state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pc_out     = 1'b0;
        mar_in     = 1'b0;
        inc_pc     = 1'b0;
        pc_in      = 1'b0;
        read       = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        z_low_out  = 1'b0;
        z_high_out = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        gpr_in     = '0;
        gpr_out    = '0;
        alu_sel    = ALU_AND;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                alu_sel = ALU_ADD;
            end
            S_T1: begin
                z_low_out = 1'b1;
                pc_in     = 1'b1;
                read      = 1'b1;
                mdr_in    = 1'b1;
            end
            S_T1W: begin
                read   = 1'b1;
                mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_BINARY: begin
                        gpr_out = rb_oh;
                        y_in    = 1'b1;
                    end
                    CLS_MULDIV: begin
                        gpr_out = ra_oh;
                        y_in    = 1'b1;
                    end
                    CLS_UNARY: begin
                        gpr_out = rb_oh;
                        z_in    = 1'b1;
                        alu_sel = dec_alu;
                    end
                    default: illegal = dec_illegal;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_BINARY: begin
                        gpr_out = rc_oh;
                        z_in    = 1'b1;
                        alu_sel = dec_alu;
                    end
                    CLS_MULDIV: begin
                        gpr_out = rb_oh;
                        z_in    = 1'b1;
                        alu_sel = dec_alu;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                z_low_out = 1'b1;
                if (cls == CLS_MULDIV) begin
                    lo_in = 1'b1;
                end else begin
                    gpr_in = ra_oh;
                    done   = 1'b1;
                end
            end
            S_T6: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign alu_op = alu_sel;

endmodule

// File: tb/tb_rtype_control_seq.sv
// Scoreboard bench for rtype_control_seq: stimulus queues the expected control
// word of every busy cycle; a monitor compares each nonzero output cycle in order.
module tb_rtype_control_seq;

    localparam int unsigned NREG = 8;
    localparam int unsigned LAT  = 3;
    localparam int unsigned W    = 17 + 4 + 2 * NREG;

    localparam logic [16:0] PC_OUT  = 17'h10000;
    localparam logic [16:0] MAR_IN  = 17'h08000;
    localparam logic [16:0] INC_PC  = 17'h04000;
    localparam logic [16:0] PC_IN   = 17'h02000;
    localparam logic [16:0] READ    = 17'h01000;
    localparam logic [16:0] MDR_IN  = 17'h00800;
    localparam logic [16:0] MDR_OUT = 17'h00400;
    localparam logic [16:0] IR_IN   = 17'h00200;
    localparam logic [16:0] Y_IN    = 17'h00100;
    localparam logic [16:0] Z_IN    = 17'h00080;
    localparam logic [16:0] Z_LOW   = 17'h00040;
    localparam logic [16:0] Z_HIGH  = 17'h00020;
    localparam logic [16:0] HI_IN   = 17'h00010;
    localparam logic [16:0] LO_IN   = 17'h00008;
    localparam logic [16:0] BUSY    = 17'h00004;
    localparam logic [16:0] DONE    = 17'h00002;
    localparam logic [16:0] ILLEGAL = 17'h00001;

    logic            clk;
    logic            reset;
    logic            start;
    logic            mem_ready;
    logic [31:0]     ir;
    logic            pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic            y_in, z_in, z_low_out, z_high_out, hi_in, lo_in;
    logic [NREG-1:0] gpr_in;
    logic [NREG-1:0] gpr_out;
    logic [3:0]      alu_op;
    logic            busy, done, illegal;
    logic [W-1:0]    obs;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];

    rtype_control_seq #(.NREG(NREG), .MULDIV_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .pc_out     (pc_out),
        .mar_in     (mar_in),
        .inc_pc     (inc_pc),
        .pc_in      (pc_in),
        .read       (read),
        .mdr_in     (mdr_in),
        .mdr_out    (mdr_out),
        .ir_in      (ir_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .z_low_out  (z_low_out),
        .z_high_out (z_high_out),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .gpr_in     (gpr_in),
        .gpr_out    (gpr_out),
        .alu_op     (alu_op),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    assign obs = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in,
                  z_low_out, z_high_out, hi_in, lo_in, busy, done, illegal,
                  alu_op, gpr_in, gpr_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] cw(input logic [16:0] s, input logic [3:0] op,
                                        input int gi, input int go);
        logic [NREG-1:0] a;
        logic [NREG-1:0] b;
        a = '0;
        b = '0;
        if (gi >= 0) a[gi] = 1'b1;
        if (go >= 0) b[go] = 1'b1;
        return {s | BUSY, op, a, b};
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    task automatic push(input logic [W-1:0] w, input string n);
        exp_q.push_back(w);
        name_q.push_back(n);
    endtask

    task automatic push_fetch(input int waits, input string tag);
        push(cw(PC_OUT | MAR_IN | INC_PC | Z_IN, 4'b0010, -1, -1), {tag, "_T0"});
        push(cw(Z_LOW | PC_IN | READ | MDR_IN, 4'b0000, -1, -1), {tag, "_T1"});
        for (int i = 0; i < waits; i++) push(cw(READ | MDR_IN, 4'b0000, -1, -1), {tag, "_T1W"});
        push(cw(MDR_OUT | IR_IN, 4'b0000, -1, -1), {tag, "_T2"});
    endtask

    task automatic push_binary(input int ra, input int rb, input int rc, input logic [3:0] op,
                               input string tag);
        push_fetch(0, tag);
        push(cw(Y_IN, 4'b0000, -1, rb), {tag, "_T3"});
        push(cw(Z_IN, op, -1, rc), {tag, "_T4"});
        push(cw(Z_LOW | DONE, 4'b0000, ra, -1), {tag, "_T5"});
    endtask

    task automatic push_muldiv(input int ra, input int rb, input logic [3:0] op, input string tag);
        push_fetch(0, tag);
        push(cw(Y_IN, 4'b0000, -1, ra), {tag, "_T3"});
        for (int i = 0; i < int'(LAT); i++) push(cw(Z_IN, op, -1, rb), {tag, "_T4"});
        push(cw(Z_LOW | LO_IN, 4'b0000, -1, -1), {tag, "_T5"});
        push(cw(Z_HIGH | HI_IN | DONE, 4'b0000, -1, -1), {tag, "_T6"});
    endtask

    task automatic push_unary(input int ra, input int rb, input logic [3:0] op, input string tag);
        push_fetch(0, tag);
        push(cw(Z_IN, op, -1, rb), {tag, "_T3"});
        push(cw(Z_LOW | DONE, 4'b0000, ra, -1), {tag, "_T5"});
    endtask

    task automatic push_illegal(input string tag);
        push_fetch(0, tag);
        push(cw(ILLEGAL, 4'b0000, -1, -1), {tag, "_T3"});
    endtask

    task automatic issue(input logic [31:0] iw, input logic mr);
        @(posedge clk);
        #1;
        ir        = iw;
        mem_ready = mr;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got=%0d_pending want=0_pending", tag, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s_idle got=%h want=0", tag, obs);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        string        n;
        if (obs !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step got=%h want=idle", obs);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL %s got=%h want=%h", n, obs, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    int          bin_op[8]  = '{3, 4, 5, 6, 7, 8, 9, 10};
    logic [3:0]  bin_alu[8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1};

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b1;
        ir        = '0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", obs);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // and R5,R2,R4
        push_binary(5, 2, 4, 4'b0000, "and");
        issue(32'h4A920000, 1'b1);
        drain("and");

        // every two-operand opcode with rotating register choices
        for (int i = 0; i < 8; i++) begin
            push_binary(i, (i + 3) % 8, (i + 5) % 8, bin_alu[i], $sformatf("bin%0d", bin_op[i]));
            issue(mk_ir(bin_op[i], i, (i + 3) % 8, (i + 5) % 8), 1'b1);
            drain($sformatf("bin%0d", bin_op[i]));
        end

        // sub R0,R3,R2 with memory stalling 3 cycles in T1
        push_fetch(3, "wait");
        push(cw(Y_IN, 4'b0000, -1, 3), "wait_T3");
        push(cw(Z_IN, 4'b0011, -1, 2), "wait_T4");
        push(cw(Z_LOW | DONE, 4'b0000, 0, -1), "wait_T5");
        issue(mk_ir(4, 0, 3, 2), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        drain("wait");

        push_muldiv(2, 4, 4'b1000, "mul");
        issue(32'h71200000, 1'b1);
        drain("mul");

        push_muldiv(7, 0, 4'b1001, "div");
        issue(mk_ir(15, 7, 0, 0), 1'b1);
        drain("div");

        push_unary(7, 3, 4'b1011, "not");
        issue(32'h8B980000, 1'b1);
        drain("not");

        push_unary(0, 7, 4'b1010, "neg");
        issue(mk_ir(16, 0, 7, 15), 1'b1);
        drain("neg");

        push_illegal("op0");
        issue(32'h00000000, 1'b1);
        drain("op0");

        push_illegal("op31");
        issue(mk_ir(31, 1, 2, 3), 1'b1);
        drain("op31");

        push_illegal("rc8");
        issue(mk_ir(3, 1, 2, 8), 1'b1);
        drain("rc8");

        push_illegal("mulra8");
        issue(mk_ir(14, 8, 1, 0), 1'b1);
        drain("mulra8");

        push_illegal("notrb9");
        issue(mk_ir(17, 1, 9, 0), 1'b1);
        drain("notrb9");

        // start pulsed mid-instruction must not restart or extend it
        push_binary(6, 1, 7, 4'b0001, "restart");
        issue(mk_ir(10, 6, 1, 7), 1'b1);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("restart");

        // reset during T4: outputs clear without waiting for a clock edge
        push_fetch(0, "rst");
        push(cw(Y_IN, 4'b0000, -1, 2), "rst_T3");
        issue(32'h4A920000, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_async got=%h want=0", obs);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_seq got=%0d_pending want=0_pending", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drain("rst");

        push_binary(5, 2, 4, 4'b0000, "post_rst");
        issue(32'h4A920000, 1'b1);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
